// File: rtl/hazard_unit.sv
// Pipeline hazard controller for a 5-stage (F/D/E/M/W) pipeline: load-use stalls,
// PC-write flushes and E-stage operand forwarding selects.
// Ports: Decode/Execute source regs (RA1D/RA2D/RA1E/RA2E), E/M/W destinations
//   (WA3E/WA3M/WA3W) and write enables, MemtoRegE, PCSD, PCSrcE in;
//   StallF/StallD/FlushD/FlushE, ForwardAE/BE, PCSrcW and saturating
//   stall_cnt/redirect_cnt out.
// All control outputs are combinational from inputs and state; reset (rst=0) is
// asynchronous and clears the pending-PC tracker and both counters.
module hazard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int PC_REG     = 15,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] RA1E,
  input  logic [REG_ADDR_W-1:0] RA2E,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic [REG_ADDR_W-1:0] WA3M,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  PCSD,
  input  logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  PCSrcW,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      redirect_cnt
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

  logic             pcs_e_q, pcs_m_q, pcs_w_q;
  logic             pcs_e_d, pcs_m_d, pcs_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic             ldrstall;
  logic             pending;

  // Memory-stage result is newer than Writeback, so it is checked first.
  // The PC register is never forwarded: its read value comes from fetch logic.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] ra,
    input logic                  wr_m,
    input logic [REG_ADDR_W-1:0] wa_m,
    input logic                  wr_w,
    input logic [REG_ADDR_W-1:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PC_ADDR) begin
      if (wr_m && (ra == wa_m))      sel = 2'b10;
      else if (wr_w && (ra == wa_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    ldrstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    // A PC write anywhere from Decode through Memory makes fetched instructions bogus.
    pending  = PCSD || pcs_e_q || pcs_m_q;

    StallF    = ldrstall || pending;
    StallD    = ldrstall;
    // Flush continues while the redirect sits in Writeback; the wrong-path
    // instruction fetched that cycle must still be squashed.
    FlushD    = pending || pcs_w_q;
    FlushE    = ldrstall;
    PCSrcW    = pcs_w_q;
    ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  end

  always_comb begin
    // A PC write stuck behind a load-use stall has not entered E yet; it is
    // picked up on the cycle the stall releases.
    pcs_e_d = PCSD && !ldrstall;
    // Condition-failed PC writes drop out here.
    pcs_m_d = PCSrcE;
    pcs_w_d = pcs_m_q;

    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (StallF && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pcs_w_q && (redirect_cnt_q != {CNT_W{1'b1}}))
      redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcs_e_q        <= 1'b0;
      pcs_m_q        <= 1'b0;
      pcs_w_q        <= 1'b0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      pcs_e_q        <= pcs_e_d;
      pcs_m_q        <= pcs_m_d;
      pcs_w_q        <= pcs_w_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit (CNT_W=4 so saturation is reachable): directed
// scenarios plus randomized traffic, all checked each cycle against a
// history-based reference model.
module tb_hazard_unit;

  localparam int AW = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int HN = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic          RegWriteM, RegWriteW, MemtoRegE, PCSD, PCSrcE;
  logic          StallF, StallD, FlushD, FlushE, PCSrcW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, redirect_cnt;

  hazard_unit #(.REG_ADDR_W(AW), .PC_REG(15), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSD(PCSD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCSrcW(PCSrcW),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-cycle history of "PC write entered E" and "PCSrcE",
  // plus running totals of stall cycles and redirects.
  bit entered_e [HN];
  bit took_src  [HN];
  int cyc = 0;
  int stall_total = 0;
  int redir_total = 0;
  bit exp_stallf, exp_pcsw;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int fwd_model(input int ra);
    if (ra == 15) return 0;
    if (RegWriteM && ra == int'(WA3M)) return 2;
    if (RegWriteW && ra == int'(WA3W)) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Checks all outputs for the current inputs, then advances one clock edge.
  task automatic step();
    bit ldr, in_e, in_m, in_w, pend;
    #1;
    ldr  = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
    in_e = rst && cyc >= 1 && entered_e[cyc-1];
    in_m = rst && cyc >= 1 && took_src[cyc-1];
    in_w = rst && cyc >= 2 && took_src[cyc-2];
    pend = PCSD || in_e || in_m;
    exp_stallf = ldr || pend;
    exp_pcsw   = in_w;
    chk("StallF", int'(StallF), int'(exp_stallf));
    chk("StallD", int'(StallD), int'(ldr));
    chk("FlushD", int'(FlushD), int'(pend || in_w));
    chk("FlushE", int'(FlushE), int'(ldr));
    chk("PCSrcW", int'(PCSrcW), int'(in_w));
    chk("ForwardAE", int'(ForwardAE), fwd_model(int'(RA1E)));
    chk("ForwardBE", int'(ForwardBE), fwd_model(int'(RA2E)));
    chk("stall_cnt", int'(stall_cnt), sat(stall_total));
    chk("redirect_cnt", int'(redirect_cnt), sat(redir_total));
    @(posedge clk);
    if (rst) begin
      entered_e[cyc] = PCSD && !ldr;
      took_src[cyc]  = PCSrcE;
      if (exp_stallf) stall_total++;
      if (exp_pcsw)   redir_total++;
    end else begin
      entered_e[cyc] = 1'b0;
      took_src[cyc]  = 1'b0;
    end
    cyc++;
  endtask

  // Asynchronous reset assertion: history in flight is discarded.
  task automatic assert_rst();
    rst = 1'b0;
    if (cyc >= 1) begin entered_e[cyc-1] = 1'b0; took_src[cyc-1] = 1'b0; end
    if (cyc >= 2) took_src[cyc-2] = 1'b0;
    stall_total = 0;
    redir_total = 0;
  endtask

  task automatic zero_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemtoRegE, PCSD, PCSrcE} = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    assert_rst();
    step();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [AW-1:0] pick_reg();
    if ($urandom_range(0, 5) == 0) return AW'(15);
    return AW'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    zero_inputs();
    rst = 1'b0;

    // Reset with PCSD held: tracker/counters clear, StallF/FlushD follow PCSD.
    PCSD = 1'b1;
    #2;
    chk("rst_stallf", int'(StallF), 1);
    chk("rst_flushd", int'(FlushD), 1);
    chk("rst_pcsrcw", int'(PCSrcW), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_redir_cnt", int'(redirect_cnt), 0);
    step();
    @(negedge clk);
    PCSD = 1'b0;
    #1;
    chk("rst_idle_outs", int'({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcW}), 0);
    step();
    @(negedge clk);
    rst = 1'b1;

    // Forwarding priority and PC exclusion.
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    #1; chk("fwdA_mem", int'(ForwardAE), 2);
    step();
    @(negedge clk); RegWriteM = 1'b0;
    #1; chk("fwdA_wb", int'(ForwardAE), 1);
    step();
    @(negedge clk); RA2E = 4'd15; WA3M = 4'd15; RegWriteM = 1'b1;
    #1; chk("fwdB_pc", int'(ForwardBE), 0);
    step();

    // Load-use stall then release.
    do_reset();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    #1; chk("ldr_flags", int'({StallF, StallD, FlushE, FlushD}), 4'b1110);
    step();
    @(negedge clk); MemtoRegE = 1'b0;
    #1; chk("ldr_after_cnt", int'(stall_cnt), 1);
    step();

    // Taken PC write: StallF 3 cycles, FlushD 4, PCSrcW in cycle 3 only.
    do_reset();
    begin
      bit [4:0] sf = 5'b00111, fd = 5'b01111, pw = 5'b01000;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        PCSD = (i == 0); PCSrcE = (i == 1);
        #1;
        chk("taken_stallf", int'(StallF), int'(sf[i]));
        chk("taken_flushd", int'(FlushD), int'(fd[i]));
        chk("taken_pcsrcw", int'(PCSrcW), int'(pw[i]));
        step();
      end
      chk("taken_redir_cnt", int'(redirect_cnt), 1);
    end

    // Condition fails: two stall/flush cycles, no redirect.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      PCSD = (i == 0); PCSrcE = 1'b0;
      #1;
      chk("nt_stallf", int'(StallF), int'(i < 2));
      chk("nt_flushd", int'(FlushD), int'(i < 2));
      chk("nt_pcsrcw", int'(PCSrcW), 0);
      step();
    end
    chk("nt_redir_cnt", int'(redirect_cnt), 0);

    // Simultaneous load-use and PCSD: PC write not tracked until the load clears.
    do_reset();
    MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2; PCSD = 1'b1;
    #1; chk("ldr_pcsd_flags", int'({StallF, StallD, FlushE, FlushD}), 4'b1111);
    step();
    @(negedge clk); MemtoRegE = 1'b0; PCSD = 1'b0;
    #1; chk("ldr_pcsd_untracked", int'(StallF), 0);
    step();

    // Saturation: 19 stall cycles leave stall_cnt at all-ones.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      if (i > 0) @(negedge clk);
      PCSD = 1'b1;
      step();
    end
    @(negedge clk); PCSD = 1'b0;
    #1; chk("sat_stall_cnt", int'(stall_cnt), CMAX);
    step();

    // Randomized traffic with occasional asynchronous resets mid-cycle.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      RA1D = pick_reg(); RA2D = pick_reg(); RA1E = pick_reg(); RA2E = pick_reg();
      WA3E = pick_reg(); WA3M = pick_reg(); WA3W = pick_reg();
      RegWriteM = ($urandom_range(0, 1) == 1);
      RegWriteW = ($urandom_range(0, 1) == 1);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCSD      = ($urandom_range(0, 5) == 0);
      PCSrcE    = ($urandom_range(0, 4) == 0);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 49) == 0) assert_rst();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
